// File: rtl/cva6_cfg_readback_pkg.sv
// Types, word map and helpers for the read-only config readback block.
// Shared by cva6_cfg_readback and its signature CRC engine.
package cva6_cfg_readback_pkg;

  typedef struct packed {
    int unsigned XLEN, VLEN, PLEN, GPLEN;
    logic RVA, RVB, RVC, RVD, RVF, RVH, RVS, RVU, RVV, RVZCB, RVZCMP;
    logic RVZiCond, RVZicntr, RVZihpm, XF16, XF16ALT, XF8, XFVec;
    logic CvxifEn, DebugEn, MmuPresent, SuperscalarEn;
    int unsigned NrCommitPorts, NrIssuePorts, NrWbPorts, NrRgprPorts, NR_SB_ENTRIES, FLen;
    int unsigned ICACHE_SET_ASSOC, ICACHE_INDEX_WIDTH, ICACHE_LINE_WIDTH;
    int unsigned DCACHE_SET_ASSOC, DCACHE_INDEX_WIDTH, DCACHE_LINE_WIDTH, DCacheType;
    int unsigned InstrTlbEntries, DataTlbEntries, SharedTlbDepth, PtLevels;
    logic [63:0] HaltAddress, ExceptionAddress, DmBaseAddress;
    int unsigned NrPMPEntries, RASDepth, BTBEntries, BHTEntries;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef enum logic {ST_SIG, ST_READY} rb_state_e;

  localparam logic [3:0] WORD_WIDTHS   = 4'd0;
  localparam logic [3:0] WORD_ISA      = 4'd1;
  localparam logic [3:0] WORD_PORTS    = 4'd2;
  localparam logic [3:0] WORD_ICACHE   = 4'd3;
  localparam logic [3:0] WORD_DCACHE   = 4'd4;
  localparam logic [3:0] WORD_MMU      = 4'd5;
  localparam logic [3:0] WORD_HALT_LO  = 4'd6;
  localparam logic [3:0] WORD_HALT_HI  = 4'd7;
  localparam logic [3:0] WORD_EXC_LO   = 4'd8;
  localparam logic [3:0] WORD_EXC_HI   = 4'd9;
  localparam logic [3:0] WORD_DM_LO    = 4'd10;
  localparam logic [3:0] WORD_DM_HI    = 4'd11;
  localparam logic [3:0] WORD_BPRED    = 4'd12;
  localparam logic [3:0] WORD_WALK_END = 4'd14;
  localparam logic [3:0] WORD_SIG      = 4'd15;

  localparam int ISA_RVA = 0,  ISA_RVB = 1,  ISA_RVC = 2,  ISA_RVD = 3,  ISA_RVF = 4;
  localparam int ISA_RVH = 5,  ISA_RVS = 6,  ISA_RVU = 7,  ISA_RVV = 8,  ISA_RVZCB = 9;
  localparam int ISA_RVZCMP = 10, ISA_RVZICOND = 11, ISA_RVZICNTR = 12, ISA_RVZIHPM = 13;
  localparam int ISA_XF16 = 14, ISA_XF16ALT = 15, ISA_XF8 = 16, ISA_XFVEC = 17;
  localparam int ISA_CVXIF = 18, ISA_DEBUG = 19, ISA_MMU = 20, ISA_SUPERSCALAR = 21;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOR  = 32'hFFFF_FFFF;

  // Values too wide for their field read back as all-ones rather than wrapping.
  function automatic logic [3:0] sat4(input int unsigned v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

  function automatic logic [7:0] sat8(input int unsigned v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [11:0] sat12(input int unsigned v);
    return (v > 32'd4095) ? 12'hFFF : v[11:0];
  endfunction

  function automatic logic [15:0] sat16(input int unsigned v);
    return (v > 32'd65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [31:0] pack_cfg_word(input cva6_cfg_t cfg, input logic [3:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      WORD_WIDTHS: w = {sat8(cfg.GPLEN), sat8(cfg.PLEN), sat8(cfg.VLEN), sat8(cfg.XLEN)};
      WORD_ISA: begin
        w[ISA_RVA] = cfg.RVA;   w[ISA_RVB] = cfg.RVB;   w[ISA_RVC] = cfg.RVC;
        w[ISA_RVD] = cfg.RVD;   w[ISA_RVF] = cfg.RVF;   w[ISA_RVH] = cfg.RVH;
        w[ISA_RVS] = cfg.RVS;   w[ISA_RVU] = cfg.RVU;   w[ISA_RVV] = cfg.RVV;
        w[ISA_RVZCB] = cfg.RVZCB;         w[ISA_RVZCMP] = cfg.RVZCMP;
        w[ISA_RVZICOND] = cfg.RVZiCond;   w[ISA_RVZICNTR] = cfg.RVZicntr;
        w[ISA_RVZIHPM] = cfg.RVZihpm;     w[ISA_XF16] = cfg.XF16;
        w[ISA_XF16ALT] = cfg.XF16ALT;     w[ISA_XF8] = cfg.XF8;
        w[ISA_XFVEC] = cfg.XFVec;         w[ISA_CVXIF] = cfg.CvxifEn;
        w[ISA_DEBUG] = cfg.DebugEn;       w[ISA_MMU] = cfg.MmuPresent;
        w[ISA_SUPERSCALAR] = cfg.SuperscalarEn;
      end
      WORD_PORTS: w = {sat8(cfg.FLen), sat8(cfg.NR_SB_ENTRIES), sat4(cfg.NrRgprPorts),
                       sat4(cfg.NrWbPorts), sat4(cfg.NrIssuePorts), sat4(cfg.NrCommitPorts)};
      WORD_ICACHE: w = {sat16(cfg.ICACHE_LINE_WIDTH), sat8(cfg.ICACHE_INDEX_WIDTH),
                        sat8(cfg.ICACHE_SET_ASSOC)};
      WORD_DCACHE: w = {sat4(cfg.DCacheType), sat12(cfg.DCACHE_LINE_WIDTH),
                        sat8(cfg.DCACHE_INDEX_WIDTH), sat8(cfg.DCACHE_SET_ASSOC)};
      WORD_MMU: w = {sat8(cfg.PtLevels), sat8(cfg.SharedTlbDepth), sat8(cfg.DataTlbEntries),
                     sat8(cfg.InstrTlbEntries)};
      WORD_HALT_LO: w = cfg.HaltAddress[31:0];
      WORD_HALT_HI: w = cfg.HaltAddress[63:32];
      WORD_EXC_LO:  w = cfg.ExceptionAddress[31:0];
      WORD_EXC_HI:  w = cfg.ExceptionAddress[63:32];
      WORD_DM_LO:   w = cfg.DmBaseAddress[31:0];
      WORD_DM_HI:   w = cfg.DmBaseAddress[63:32];
      WORD_BPRED: w = {sat8(cfg.BHTEntries), sat8(cfg.BTBEntries), sat8(cfg.RASDepth),
                       sat8(cfg.NrPMPEntries)};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Whole word folded in MSB-first, equivalent to feeding its bits one at a time.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] word);
    logic [31:0] c;
    c = crc ^ word;
    for (int i = 0; i < 32; i++) begin
      c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/cva6_cfg_sig_crc32.sv
// CRC-32 accumulator: folds one 32-bit word per enabled cycle into a running state.
module cva6_cfg_sig_crc32
  import cva6_cfg_readback_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        step_i,
  input  logic [31:0] word_i,
  output logic [31:0] crc_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_o <= CRC32_INIT;
    end else if (step_i) begin
      crc_o <= crc32_word(crc_o, word_i);
    end
  end

endmodule

// File: rtl/cva6_cfg_readback.sv
// Read-only responder exposing the elaborated core config as indexed 32-bit words.
// Define CVA6_CFG_READBACK_SIGNATURE_EN to add the power-on CRC-32 signature walk (word 15).
module cva6_cfg_readback
  import cva6_cfg_readback_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg  = cva6_cfg_empty,
  parameter int unsigned IdxWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IdxWidth-1:0] req_idx_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o
);

`ifdef CVA6_CFG_READBACK_SIGNATURE_EN
  localparam bit SigEn = 1'b1;
`else
  localparam bit SigEn = 1'b0;
`endif

  rb_state_e   state;
  logic [3:0]  walk_idx;
  logic [31:0] walk_word;
  logic [31:0] crc_state;
  logic [31:0] signature;
  logic        idx_in_range;
  logic [31:0] rd_word;

  // Walks words 0..14 once after reset; READY is terminal until the next reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= SigEn ? ST_SIG : ST_READY;
      walk_idx <= '0;
    end else if (state == ST_SIG) begin
      walk_idx <= walk_idx + 4'd1;
      if (walk_idx == WORD_WALK_END) begin
        state <= ST_READY;
      end
    end
  end

  assign walk_word = pack_cfg_word(CVA6Cfg, walk_idx);
  assign busy_o    = SigEn && (state == ST_SIG);

  cva6_cfg_sig_crc32 u_sig_crc32 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .step_i (busy_o),
    .word_i (walk_word),
    .crc_o  (crc_state)
  );

  assign signature = SigEn ? (crc_state ^ CRC32_XOR) : 32'd0;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // rsp_valid_o, once raised, holds with stable rdata/err until rsp_ready_i; a response
  // being consumed frees the single slot for a new request in that same cycle.
  assign req_ready_o = (state == ST_READY) && (!rsp_valid_o || rsp_ready_i);

  assign idx_in_range = (32'(req_idx_i) < 32'd16);
  assign rd_word = !idx_in_range            ? 32'd0 :
                   (req_idx_i[3:0] == WORD_SIG) ? signature :
                   pack_cfg_word(CVA6Cfg, req_idx_i[3:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (req_valid_i && req_ready_o) begin
      rsp_valid_o <= 1'b1;
      rsp_rdata_o <= rd_word;
      rsp_err_o   <= !idx_in_range;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cva6_cfg_readback.sv
// Scoreboard bench for cva6_cfg_readback with a cv64a6-style config and hand-computed words.
module tb_cva6_cfg_readback;
  import cva6_cfg_readback_pkg::*;

  localparam cva6_cfg_t TB_CFG = '{
    XLEN: 64, VLEN: 64, PLEN: 56, GPLEN: 41,
    RVA: 1'b1, RVB: 1'b0, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVH: 1'b0, RVS: 1'b1,
    RVU: 1'b1, RVV: 1'b0, RVZCB: 1'b1, RVZCMP: 1'b0, RVZiCond: 1'b1, RVZicntr: 1'b1,
    RVZihpm: 1'b1, XF16: 1'b0, XF16ALT: 1'b0, XF8: 1'b0, XFVec: 1'b0,
    CvxifEn: 1'b1, DebugEn: 1'b1, MmuPresent: 1'b1, SuperscalarEn: 1'b0,
    NrCommitPorts: 2, NrIssuePorts: 1, NrWbPorts: 20, NrRgprPorts: 2, NR_SB_ENTRIES: 8, FLen: 64,
    ICACHE_SET_ASSOC: 4, ICACHE_INDEX_WIDTH: 12, ICACHE_LINE_WIDTH: 128,
    DCACHE_SET_ASSOC: 8, DCACHE_INDEX_WIDTH: 12, DCACHE_LINE_WIDTH: 128, DCacheType: 2,
    InstrTlbEntries: 16, DataTlbEntries: 16, SharedTlbDepth: 64, PtLevels: 3,
    HaltAddress: 64'h0000_0001_0000_0800, ExceptionAddress: 64'h808, DmBaseAddress: 64'h0,
    NrPMPEntries: 8, RASDepth: 2, BTBEntries: 32, BHTEntries: 300
  };

`ifdef CVA6_CFG_READBACK_SIGNATURE_EN
  localparam int EXP_BUSY = 15;
`else
  localparam int EXP_BUSY = 0;
`endif

  // Hand-computed words 0..14 for TB_CFG (NrWbPorts and BHTEntries saturate).
  localparam logic [31:0] EXP_WORDS [15] = '{
    32'h2938_4040, 32'h001C_3ADD, 32'h4008_2F12, 32'h0080_0C04, 32'h2080_0C08,
    32'h0340_1010, 32'h0000_0800, 32'h0000_0001, 32'h0000_0808, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'hFF20_0208, 32'h0000_0000, 32'h0000_0000
  };

  logic        clk, rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [7:0]  req_idx;
  logic [31:0] rsp_rdata;

  logic [32:0] exp_q[$];
  int          rsp_cyc[$];
  int          cyc;
  int          checks, errors;
  logic [31:0] sig_exp;

  cva6_cfg_readback #(.CVA6Cfg(TB_CFG), .IdxWidth(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_idx_i   (req_idx),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    end
  endtask

  // Byte-serial MSB-first CRC-32 model over the expected words.
  function automatic logic [31:0] crc_model();
    logic [31:0] c;
    logic [31:0] w;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 15; i++) begin
      w = EXP_WORDS[i];
      for (int b = 3; b >= 0; b--) begin
        c = c ^ {w[b*8 +: 8], 24'd0};
        for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      end
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction

  function automatic logic [32:0] exp_of(input int idx);
    if (idx >= 16) return {1'b1, 32'd0};
    if (idx == 15) return {1'b0, sig_exp};
    return {1'b0, EXP_WORDS[idx]};
  endfunction

  // Monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {rsp_err, rsp_rdata}, 33'h1_FFFF_FFFF);
      end else begin
        check("rsp", {rsp_err, rsp_rdata}, exp_q.pop_front());
      end
      rsp_cyc.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic issue_read(input logic [7:0] idx, input logic [32:0] exp);
    bit done;
    done = 1'b0;
    req_valid = 1'b1;
    req_idx   = idx;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("req_accept_timeout", 33'd0, 33'd1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic walk_check();
    int cnt, viol;
    cnt = 0;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (req_ready) viol++;
    end
    check("busy_cycles", 33'(cnt), 33'(EXP_BUSY));
    check("ready_during_walk", 33'(viol), 33'd0);
    check("ready_after_walk", {32'd0, req_ready}, 33'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    walk_check();
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0;
    sig_exp = (EXP_BUSY != 0) ? crc_model() : 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_idx = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", {32'd0, rsp_valid}, 33'd0);
    check("reset_rdata_err", {rsp_err, rsp_rdata}, 33'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    walk_check();

    // Every index once (including 15, 16 and far out-of-range), then a back-to-back burst.
    for (int i = 0; i <= 16; i++) begin
      issue_read(8'(i), exp_of(i));
      idle(1);
    end
    issue_read(8'd200, exp_of(200));
    idle(3);
    n = rsp_cyc.size();
    issue_read(8'd0, exp_of(0));
    issue_read(8'd1, exp_of(1));
    issue_read(8'd2, exp_of(2));
    idle(3);
    check("b2b_count", 33'(rsp_cyc.size() - n), 33'd3);
    if (rsp_cyc.size() - n == 3) begin
      check("b2b_gap0", 33'(rsp_cyc[n+1] - rsp_cyc[n]), 33'd1);
      check("b2b_gap1", 33'(rsp_cyc[n+2] - rsp_cyc[n+1]), 33'd1);
    end

    // Back-pressure: idx 6 held for 5 cycles while another request waits.
    rsp_ready = 1'b0;
    issue_read(8'd6, exp_of(6));
    req_idx = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid_data", {rsp_valid, rsp_rdata}, {1'b1, 32'h0000_0800});
      check("stall_req_ready", {32'd0, req_ready}, 33'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    issue_read(8'd0, exp_of(0));
    idle(3);

    // Reset while a response is pending, then reset mid-walk, then re-read the signature.
    rsp_ready = 1'b0;
    issue_read(8'd3, exp_of(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_rsp", {rsp_valid, rsp_rdata}, 33'd0);
    do_reset();
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    do_reset();
    issue_read(8'd15, exp_of(15));
    idle(1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", 33'(exp_q.size()), 33'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
